// File: rtl/rgb_frame_reader_pkg.sv
// Shared types and constants for the packed-RGB frame reader.
package rgb_frame_reader_pkg;

  localparam int unsigned SRAM_AW         = 18;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned PIX_W           = 8;
  localparam int unsigned RGB_BASE        = 146944;
  localparam int unsigned WORDS_PER_FRAME = 320 * 240 * 3 / 2;

  typedef enum logic [1:0] {F_IDLE, F_RUN, F_DRAIN} fstate_e;
  typedef enum logic [1:0] {U_W0, U_W1, U_W2} ustate_e;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/rgb_frame_reader_if.sv
// SRAM read port and pixel-stream handshake shared by the frame reader and its neighbours.
interface rgb_frame_reader_if;
  import rgb_frame_reader_pkg::*;

  logic [SRAM_AW-1:0] SRAM_address;
  logic               SRAM_we_n;
  logic [SRAM_DW-1:0] SRAM_read_data;
  logic               sram_grant;
  logic [PIX_W-1:0]   pix_R;
  logic [PIX_W-1:0]   pix_G;
  logic [PIX_W-1:0]   pix_B;
  logic               pix_valid;
  logic               pix_ready;
  logic               pix_eol;

  modport master (
    output SRAM_address, SRAM_we_n, pix_R, pix_G, pix_B, pix_valid, pix_eol,
    input  SRAM_read_data, sram_grant, pix_ready
  );

  modport slave (
    input  SRAM_address, SRAM_we_n, pix_R, pix_G, pix_B, pix_valid, pix_eol,
    output SRAM_read_data, sram_grant, pix_ready
  );

endinterface

// File: rtl/rgb_frame_reader_word_fifo.sv
// rgb_word_fifo: synchronous first-word-fall-through FIFO with occupancy count.
module rgb_word_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata_c,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;

  assign w_full    = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Upstream credit accounting must make this unreachable.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && w_full));

endmodule

// File: rtl/rgb_frame_reader.sv
// Reads a packed RGB frame (2 pixels per 3 words) from SRAM and streams 24-bit pixels in raster order.
// Optional RGB_CHECKSUM_EN adds frame_checksum, the sum of all words fetched this frame.
module rgb_frame_reader #(
  parameter int unsigned IMG_WIDTH    = 320,
  parameter int unsigned IMG_HEIGHT   = 240,
  parameter int unsigned RGB_BASE     = rgb_frame_reader_pkg::RGB_BASE,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic               CLOCK_50_I,
  input  logic               Resetn,
  input  logic               start,
  rgb_frame_reader_if.master bus,
  output logic               busy,
  output logic               frame_done
`ifdef RGB_CHECKSUM_EN
  , output logic [31:0]      frame_checksum
`endif
);
  import rgb_frame_reader_pkg::*;

  localparam int unsigned WORDS = IMG_WIDTH * IMG_HEIGHT * 3 / 2;
  localparam int unsigned CW    = $clog2(WORDS + 1);
  localparam int unsigned XW    = $clog2(IMG_WIDTH + 1);
  localparam int unsigned YW    = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IFW   = $clog2(READ_LATENCY + 1);

  fstate_e                 r_fstate, w_fstate_nxt;
  ustate_e                 r_ustate, w_ustate_nxt;
  logic                    r_busy, r_frame_done;
  logic                    w_issue, w_start_frame, w_done_nxt, w_credit_ok;
  logic [CW-1:0]           r_issue_cnt;
  logic [SRAM_AW-1:0]      r_addr;
  logic [READ_LATENCY-1:0] r_rd_vld;
  logic [IFW-1:0]          w_in_flight;
  logic                    w_push, w_pop, w_load, w_accept, w_last_accept;
  logic [SRAM_DW-1:0]      w_fifo_rdata_c;
  logic [FCW-1:0]          w_fifo_count;
  logic                    w_fifo_empty_c;
  pixel_t                  r_pix;
  logic                    r_pix_valid, r_pix_eol;
  logic [PIX_W-1:0]        r_hold_r, r_hold_g;
  logic [XW-1:0]           r_lx;
  logic [YW-1:0]           r_y;

  // Reads still in the latency pipe already own a FIFO slot.
  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) w_in_flight = w_in_flight + IFW'(r_rd_vld[i]);
  end

  assign w_credit_ok   = (32'(w_fifo_count) + 32'(w_in_flight)) < FIFO_DEPTH;
  assign w_push        = r_rd_vld[READ_LATENCY-1];
  assign w_accept      = r_pix_valid && bus.pix_ready;
  assign w_pop         = !w_fifo_empty_c && (!r_pix_valid || bus.pix_ready);
  assign w_load        = w_pop && (r_ustate != U_W0);
  assign w_last_accept = w_accept && r_pix_eol && (r_y == YW'(IMG_HEIGHT - 1));

  always_comb begin
    w_fstate_nxt  = r_fstate;
    w_issue       = 1'b0;
    w_start_frame = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_fstate)
      F_IDLE: if (start) begin
        w_start_frame = 1'b1;
        w_fstate_nxt  = F_RUN;
      end
      F_RUN: begin
        w_issue = bus.sram_grant && w_credit_ok;
        if (w_issue && (r_issue_cnt == CW'(WORDS - 1))) w_fstate_nxt = F_DRAIN;
      end
      F_DRAIN: if (w_last_accept) begin
        w_fstate_nxt = F_IDLE;
        w_done_nxt   = 1'b1;
      end
      default: w_fstate_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!Resetn) begin
      r_fstate     <= F_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_fstate     <= w_fstate_nxt;
      r_busy       <= (w_fstate_nxt != F_IDLE);
      r_frame_done <= w_done_nxt;
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!Resetn) begin
      r_addr      <= SRAM_AW'(RGB_BASE);
      r_issue_cnt <= '0;
      r_rd_vld    <= '0;
    end else begin
      if (w_start_frame) begin
        r_issue_cnt <= '0;
      end else if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + CW'(1);
        r_addr      <= SRAM_AW'(RGB_BASE + 32'(r_issue_cnt));
      end
      r_rd_vld <= READ_LATENCY'({r_rd_vld, w_issue});
    end
  end

  rgb_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SRAM_DW)) u_fifo (
    .i_clk     (CLOCK_50_I),
    .i_rst_n   (Resetn),
    .i_push    (w_push),
    .i_wdata   (bus.SRAM_read_data),
    .i_pop     (w_pop),
    .o_rdata_c (w_fifo_rdata_c),
    .o_count   (w_fifo_count),
    .o_empty_c (w_fifo_empty_c)
  );

  always_comb begin
    w_ustate_nxt = r_ustate;
    if (w_pop) begin
      case (r_ustate)
        U_W0:    w_ustate_nxt = U_W1;
        U_W1:    w_ustate_nxt = U_W2;
        default: w_ustate_nxt = U_W0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!Resetn) r_ustate <= U_W0;
    else         r_ustate <= w_ustate_nxt;
  end

  // W0 -> {R,G}; W1 completes the even pixel and carries R'; W2 completes the odd pixel.
  always_ff @(posedge CLOCK_50_I) begin
    if (!Resetn) begin
      r_pix       <= '0;
      r_pix_valid <= 1'b0;
      r_pix_eol   <= 1'b0;
      r_hold_r    <= '0;
      r_hold_g    <= '0;
      r_lx        <= '0;
      r_y         <= '0;
    end else begin
      if (w_accept) begin
        r_pix_valid <= 1'b0;
        r_pix_eol   <= 1'b0;
        if (r_pix_eol) r_y <= (r_y == YW'(IMG_HEIGHT - 1)) ? '0 : r_y + YW'(1);
      end
      if (w_pop) begin
        case (r_ustate)
          U_W0: begin
            r_hold_r <= w_fifo_rdata_c[15:8];
            r_hold_g <= w_fifo_rdata_c[7:0];
          end
          U_W1: begin
            r_pix    <= '{r: r_hold_r, g: r_hold_g, b: w_fifo_rdata_c[15:8]};
            r_hold_r <= w_fifo_rdata_c[7:0];
          end
          default: r_pix <= '{r: r_hold_r, g: w_fifo_rdata_c[15:8], b: w_fifo_rdata_c[7:0]};
        endcase
      end
      if (w_load) begin
        r_pix_valid <= 1'b1;
        r_pix_eol   <= (r_lx == XW'(IMG_WIDTH - 1));
        r_lx        <= (r_lx == XW'(IMG_WIDTH - 1)) ? '0 : r_lx + XW'(1);
      end
    end
  end

`ifdef RGB_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge CLOCK_50_I) begin
    if (!Resetn)            r_checksum <= '0;
    else if (w_start_frame) r_checksum <= '0;
    else if (w_push)        r_checksum <= r_checksum + 32'(bus.SRAM_read_data);
  end

  assign frame_checksum = r_checksum;
`endif

  assign bus.SRAM_address = r_addr;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.pix_R        = r_pix.r;
  assign bus.pix_G        = r_pix.g;
  assign bus.pix_B        = r_pix.b;
  assign bus.pix_valid    = r_pix_valid;
  assign bus.pix_eol      = r_pix_eol;
  assign busy             = r_busy;
  assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_rgb_frame_reader.sv
// Directed bench for rgb_frame_reader on a reduced 8x4 frame with a 2-cycle SRAM model.
module tb_rgb_frame_reader;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int NPIX   = W * H;
  localparam int WORDS  = NPIX * 3 / 2;
  localparam int BASE   = 146944;
  localparam int MAXCYC = 3000;

  logic clk = 1'b0;
  logic rst_n, start, busy, frame_done;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  rgb_frame_reader_if bus();
`ifdef RGB_CHECKSUM_EN
  logic [31:0] frame_checksum;
`endif

  rgb_frame_reader #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .RGB_BASE(BASE), .READ_LATENCY(2), .FIFO_DEPTH(8)
  ) dut (
    .CLOCK_50_I (clk),
    .Resetn     (rst_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef RGB_CHECKSUM_EN
    , .frame_checksum (frame_checksum)
`endif
  );

  function automatic logic [15:0] word_at(int k);
    case (k)
      0:       return 16'hAABB;
      1:       return 16'hCCDD;
      2:       return 16'hEEFF;
      default: return 16'(k * 311 + 4608);
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(int p);
    logic [15:0] w0, w1, w2;
    int j;
    j  = p / 2;
    w0 = word_at(3 * j);
    w1 = word_at(3 * j + 1);
    w2 = word_at(3 * j + 2);
    if (p % 2 == 0) return {w0, w1[15:8]};
    return {w1[7:0], w2};
  endfunction

  // SRAM: data for the address driven two edges earlier is sampled by the DUT.
  logic [17:0] a1;
  bit          all_ones = 1'b0;
  always @(posedge clk) a1 <= bus.SRAM_address;
  assign bus.SRAM_read_data = all_ones ? 16'h0001 : word_at(int'(a1) - BASE);

  logic [23:0] q_pix[$];
  bit          q_eol[$];
  int          first_valid_cyc, hs_last_cyc, done_cyc, done_pulses, stall_viol, addr_viol, start_cyc;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_pix;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && (!bus.pix_valid || {bus.pix_R, bus.pix_G, bus.pix_B} !== prev_pix))
        stall_viol++;
      if (bus.pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.pix_valid && bus.pix_ready) begin
        q_pix.push_back({bus.pix_R, bus.pix_G, bus.pix_B});
        q_eol.push_back(bus.pix_eol);
        hs_last_cyc = cyc;
      end
      if (frame_done) begin
        done_pulses++;
        done_cyc = cyc;
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_pix   = {bus.pix_R, bus.pix_G, bus.pix_B};
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic int seq_errors();
    int e = 0;
    if (q_pix.size() != NPIX) e++;
    for (int p = 0; p < q_pix.size() && p < NPIX; p++) begin
      if (q_pix[p] !== exp_pix(p)) e++;
      if (q_eol[p] !== (p % W == W - 1)) e++;
    end
    return e;
  endfunction

  task automatic run_frame(input bit rand_rdy, input int gap_at, input int gap_len, input int restart_at);
    int          post;
    logic [17:0] gap_addr;
    q_pix.delete();
    q_eol.delete();
    first_valid_cyc = -1; hs_last_cyc = -1; done_cyc = -1;
    done_pulses = 0; stall_viol = 0; addr_viol = 0; post = 0; gap_addr = '0;
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc; bus.sram_grant = 1'b1; bus.pix_ready = 1'b1;
    for (int i = 0; i < MAXCYC && post < 4; i++) begin
      @(posedge clk); #1;
      start          = (i == restart_at);
      bus.pix_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.sram_grant = !(i >= gap_at && i < gap_at + gap_len);
      @(negedge clk);
      if (i == gap_at) gap_addr = bus.SRAM_address;
      else if (i > gap_at && i < gap_at + gap_len && bus.SRAM_address !== gap_addr) addr_viol++;
      if (done_cyc >= 0) post++;
    end
    start = 1'b0; bus.pix_ready = 1'b1; bus.sram_grant = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bus.sram_grant = 1'b1; bus.pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.SRAM_address !== 18'(BASE)) begin errors++; $display("FAIL reset_addr got %0d want %0d", bus.SRAM_address, BASE); end
    checks++; if (bus.SRAM_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b want 1", bus.SRAM_we_n); end
    checks++; if ({bus.pix_R, bus.pix_G, bus.pix_B} !== 24'h0) begin errors++; $display("FAIL reset_pix got %h want 000000", {bus.pix_R, bus.pix_G, bus.pix_B}); end
    checks++; if (bus.pix_valid !== 1'b0 || bus.pix_eol !== 1'b0) begin errors++; $display("FAIL reset_valid_eol got %b%b want 00", bus.pix_valid, bus.pix_eol); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, frame_done); end
`ifdef RGB_CHECKSUM_EN
    checks++; if (frame_checksum !== 32'd0) begin errors++; $display("FAIL reset_checksum got %0d want 0", frame_checksum); end
`endif
  endtask

  task automatic test_first_pixel();
    run_frame(1'b0, -1, 0, -1);
    checks++; if (first_valid_cyc - start_cyc !== 6) begin errors++; $display("FAIL first_latency got %0d want 6", first_valid_cyc - start_cyc); end
    checks++; if (q_pix.size() < 1 || q_pix[0] !== 24'hAABBCC) begin errors++; $display("FAIL pixel0 got %h want aabbcc", q_pix.size() > 0 ? q_pix[0] : 24'h0); end
    checks++; if (q_pix.size() < 2 || q_pix[1] !== 24'hDDEEFF) begin errors++; $display("FAIL pixel1 got %h want ddeeff", q_pix.size() > 1 ? q_pix[1] : 24'h0); end
  endtask

  task automatic test_full_frame();
    int eols = 0;
    run_frame(1'b0, -1, 0, -1);
    foreach (q_eol[k]) eols += int'(q_eol[k]);
    checks++; if (q_pix.size() !== NPIX) begin errors++; $display("FAIL full_count got %0d want %0d", q_pix.size(), NPIX); end
    checks++; if (seq_errors() !== 0) begin errors++; $display("FAIL full_sequence bad %0d want 0", seq_errors()); end
    checks++; if (eols !== H) begin errors++; $display("FAIL full_eol_count got %0d want %0d", eols, H); end
    checks++; if (bus.SRAM_address !== 18'(BASE + WORDS - 1)) begin errors++; $display("FAIL full_last_addr got %0d want %0d", bus.SRAM_address, BASE + WORDS - 1); end
    checks++; if (done_pulses !== 1 || done_cyc !== hs_last_cyc + 1) begin errors++; $display("FAIL full_done pulses %0d at %0d want 1 at %0d", done_pulses, done_cyc, hs_last_cyc + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy); end
  endtask

  task automatic test_random_ready();
    run_frame(1'b1, -1, 0, 20);
    checks++; if (seq_errors() !== 0) begin errors++; $display("FAIL rand_sequence bad %0d want 0", seq_errors()); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL rand_stall_stable got %0d want 0", stall_viol); end
    checks++; if (done_pulses !== 1 || done_cyc !== hs_last_cyc + 1) begin errors++; $display("FAIL rand_done pulses %0d at %0d want 1 at %0d", done_pulses, done_cyc, hs_last_cyc + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy_after got %b want 0", busy); end
  endtask

  task automatic test_grant_gap();
    run_frame(1'b0, 10, 20, -1);
    checks++; if (addr_viol !== 0) begin errors++; $display("FAIL gap_addr_frozen got %0d moves want 0", addr_viol); end
    checks++; if (seq_errors() !== 0) begin errors++; $display("FAIL gap_sequence bad %0d want 0", seq_errors()); end
    checks++; if (bus.SRAM_address !== 18'(BASE + WORDS - 1)) begin errors++; $display("FAIL gap_last_addr got %0d want %0d", bus.SRAM_address, BASE + WORDS - 1); end
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL gap_done got %0d want 1", done_pulses); end
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b want 1", busy); end
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.SRAM_address !== 18'(BASE)) begin errors++; $display("FAIL abort_addr got %0d want %0d", bus.SRAM_address, BASE); end
    checks++; if (bus.pix_valid !== 1'b0 || {bus.pix_R, bus.pix_G, bus.pix_B} !== 24'h0) begin errors++; $display("FAIL abort_pix got %b %h want 0 000000", bus.pix_valid, {bus.pix_R, bus.pix_G, bus.pix_B}); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || bus.pix_eol !== 1'b0) begin errors++; $display("FAIL abort_flags got %b%b%b want 000", busy, frame_done, bus.pix_eol); end
    run_frame(1'b0, -1, 0, -1);
    checks++; if (first_valid_cyc - start_cyc !== 6) begin errors++; $display("FAIL abort_relatency got %0d want 6", first_valid_cyc - start_cyc); end
    checks++; if (seq_errors() !== 0) begin errors++; $display("FAIL abort_sequence bad %0d want 0", seq_errors()); end
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL abort_done got %0d want 1", done_pulses); end
  endtask

`ifdef RGB_CHECKSUM_EN
  task automatic test_checksum();
    all_ones = 1'b1;
    run_frame(1'b0, -1, 0, -1);
    all_ones = 1'b0;
    checks++; if (frame_checksum !== 32'(WORDS)) begin errors++; $display("FAIL checksum got %0d want %0d", frame_checksum, WORDS); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_pixel();
    test_full_frame();
    test_random_ready();
    test_grant_gap();
    test_reset_mid_frame();
`ifdef RGB_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
